// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Width of a port index; at least one bit even for tiny configurations.
  function automatic int port_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// Tag FIFO remembering which port owns each outstanding read, in issue order.
// A pop while empty is ignored; a push while full succeeds only alongside a pop.
module sdram_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset empties the FIFO and discards all tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; contents are meaningless outside the occupied window, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sdram_port_arb.sv
// Round-robin arbiter funnelling NUM_PORTS manager ports onto one SDRAM
// controller port, with in-order routing of read returns back to their owners.
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int WORD_LEN        = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*WORD_LEN-1:0]    p_wr,
  input  logic [NUM_PORTS-1:0]             p_rd,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  p_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  p_write_data,
  output logic [NUM_PORTS-1:0]             p_rdy,
  output logic [NUM_PORTS-1:0]             p_valid,
  output logic [NUM_PORTS-1:0]             p_error,
  output logic [DATA_WIDTH-1:0]            p_read_data,
  output logic [WORD_LEN-1:0]              m_wr,
  output logic                             m_rd,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic [DATA_WIDTH-1:0]            m_write_data,
  input  logic                             m_rdy,
  input  logic                             m_valid,
  input  logic                             m_error,
  input  logic [DATA_WIDTH-1:0]            m_read_data,
  output logic                             orphan
);

  localparam int PW = port_idx_w(NUM_PORTS);

  arb_state_e           state_q, state_d;
  logic [PW-1:0]        grant_q, grant_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 orphan_q, orphan_d;
  logic [NUM_PORTS-1:0] active;
  logic                 found;
  logic                 busy;
  logic                 grant_rd;
  logic                 accept;
  logic                 tag_full, tag_empty;
  logic [PW-1:0]        tag_head;
  logic                 ret_hit;

  // A port is requesting when any byte enable or its read strobe is raised.
  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      active[i] = (|p_wr[i*WORD_LEN +: WORD_LEN]) | p_rd[i];
    end
  end

  // A read may only issue when its tag has somewhere to go; a same-cycle return frees a slot.
  assign busy     = (state_q == BUSY) & ~rst;
  assign grant_rd = p_rd[grant_q];
  assign accept   = busy & m_rdy & ~(grant_rd & tag_full & ~m_valid);
  assign ret_hit  = m_valid & ~tag_empty & ~rst;

  // FSM state register: grant and round-robin pointer live with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // FSM next state: pick the first active port at or after rr_ptr, release on acceptance.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    case (state_q)
      IDLE: begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (!found && active[(int'(rr_ptr_q) + i) % NUM_PORTS]) begin
            found   = 1'b1;
            grant_d = PW'((int'(rr_ptr_q) + i) % NUM_PORTS);
          end
        end
        if (found) state_d = BUSY;
      end
      BUSY: begin
        if (accept) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: mirror the granted port while BUSY, route returns by FIFO head.
  always_comb begin
    m_wr         = '0;
    m_rd         = 1'b0;
    m_addr       = '0;
    m_write_data = '0;
    p_rdy        = '0;
    p_valid      = '0;
    p_error      = '0;
    p_read_data  = m_read_data;
    if (busy) begin
      m_wr           = p_wr[grant_q*WORD_LEN +: WORD_LEN];
      m_rd           = grant_rd;
      m_addr         = p_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
      m_write_data   = p_write_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
      p_rdy[grant_q] = accept;
    end
    p_valid[tag_head] = ret_hit;
    p_error[tag_head] = ret_hit & m_error;
  end

  // A return with nothing outstanding latches the orphan flag until reset.
  assign orphan_d = orphan_q | (m_valid & tag_empty);

  // Sticky orphan register.
  always_ff @(posedge clk) begin
    if (rst) orphan_q <= 1'b0;
    else     orphan_q <= orphan_d;
  end

  assign orphan = orphan_q;

  sdram_tag_fifo #(
    .WIDTH (PW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept & grant_rd),
    .push_data (grant_q),
    .pop       (m_valid & ~rst),
    .full      (tag_full),
    .empty     (tag_empty),
    .head      (tag_head)
  );

endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
- REQ-001 SHALL have parameter NUM_PORTS, default 4, meaning number of upstream manager ports (2..8).
- REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
- REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning data word width.
- REQ-004 SHALL have parameter WORD_LEN, default DATA_WIDTH/8, meaning byte-lane write-enable count.
- REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of accepted-but-unreturned reads (power of two, 2..16).
- REQ-006 clk  input  1  single clock; all logic on its rising edge.
- REQ-007 rst  input  1  reset, synchronous, active-high.
- REQ-008 p_wr  input  NUM_PORTS*WORD_LEN  per-port byte write enables.
- REQ-009 p_rd  input  NUM_PORTS  per-port read request.
- REQ-010 p_addr  input  NUM_PORTS*ADDR_WIDTH  per-port address.
- REQ-011 p_write_data  input  NUM_PORTS*DATA_WIDTH  per-port write data.
- REQ-012 p_rdy  output  NUM_PORTS  per-port accept strobe.
- REQ-013 p_valid, p_error  output  NUM_PORTS each  per-port read-return strobe and error flag.
- REQ-014 p_read_data  output  DATA_WIDTH  read data, broadcast to all ports and qualified by p_valid.
- REQ-015 m_wr, m_rd, m_addr, m_write_data  output  WORD_LEN/1/ADDR_WIDTH/DATA_WIDTH  request to the controller.
- REQ-016 m_rdy, m_valid, m_error, m_read_data  input  1/1/1/DATA_WIDTH  controller accept, return strobe, error flag and return data.
- REQ-017 orphan  output  1  sticky flag: m_valid arrived while no read was outstanding.

Function
- REQ-018 A port request SHALL be active when any bit of its p_wr is set or its p_rd is set; a port SHALL NOT assert both, and SHALL hold the request stable until p_rdy.
- REQ-019 The FSM SHALL have two states. In IDLE it registers a grant to the first active port at or after rr_ptr in round-robin order and moves to BUSY; with no active port it stays in IDLE.
- REQ-020 In BUSY, the m_* request outputs SHALL mirror the granted port combinationally. All other cycles SHALL drive m_wr=0, m_rd=0, m_addr=0 and m_write_data=0.
- REQ-021 Acceptance = BUSY & m_rdy & ~(m_rd & tag FIFO full); p_rdy[g] SHALL equal acceptance, and all other p_rdy bits SHALL be 0.
- REQ-022 On acceptance the FSM SHALL return to IDLE and set rr_ptr = (g+1) mod NUM_PORTS. Minimum request-to-accept latency SHALL be 2 cycles, and issue throughput SHALL be at most one request per 2 cycles.
- REQ-023 An accepted read SHALL push port index g into the tag FIFO. Writes SHALL push nothing.
- REQ-024 On m_valid the FIFO head SHALL be popped, and p_valid[head] and p_error[head] (=m_error) SHALL be asserted combinationally. m_read_data SHALL pass through to p_read_data.
- REQ-025 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full (count unchanged) and when it is empty with a bypass not allowed (pop ignored, orphan set).
- REQ-026 m_valid with an empty FIFO SHALL assert no p_valid and SHALL set orphan until rst.
- REQ-027 Port index SHALL wrap modulo NUM_PORTS. FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.

Reset
- REQ-028 On rst the block SHALL clear: state=IDLE, rr_ptr=0, FIFO empty, orphan=0, all p_rdy/p_valid/p_error=0, all m_* request outputs=0.
- REQ-029 Reset mid-operation SHALL drop the grant and all outstanding tags. Returns arriving after reset SHALL be treated per REQ-026.

Structure
- REQ-030 Package sdram_arb_pkg SHALL hold the state enum (IDLE, BUSY) and the port-index width constant $clog2(NUM_PORTS) helper.
- REQ-031 The tag FIFO SHALL be the sub-module sdram_tag_fifo (parameters WIDTH, DEPTH; outputs full, empty and head).

Verification
- REQ-032 Single write: port 1 requests wr=4'hF, addr=0x100, data=0xDEADBEEF, m_rdy=1 -> m_wr=4'hF at cycle+1, p_rdy[1] pulses once, orphan=0.
- REQ-033 Round-robin: all 4 ports read continuously, m_rdy=1 -> grant order 0,1,2,3,0 with one grant per 2 cycles.
- REQ-034 Return routing: ports 2 then 0 read; controller returns 0x11 then 0x22 -> p_valid[2] with 0x11, then p_valid[0] with 0x22.
- REQ-035 FIFO full: 4 reads accepted with no returns; a 5th read stalls (p_rdy=0). One m_valid then allows acceptance in the same cycle.
- REQ-036 Orphan and reset: m_valid with FIFO empty -> orphan=1 and no p_valid. rst with 2 reads outstanding -> FIFO empty and state IDLE at the next cycle.
